// File: rtl/ula_arbiter.sv
// Two-port round-robin arbiter and sequencer around a shared 32-bit ALU (ula).
// Optional opcode check is enabled with the ULA_ARB_OPCHECK_EN macro.

module ula #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             ov,
  output logic             zero,
  output logic             neg
);
  logic [WIDTH-1:0] bm;
  logic [WIDTH-1:0] sum;
  logic             ovf;

  // op[2] inverts B and injects carry-in, giving SUB, AND-NOT, OR-NOT and SLT
  always_comb begin
    bm  = op[2] ? ~b : b;
    sum = a + bm + {{(WIDTH-1){1'b0}}, op[2]};
    ovf = (a[WIDTH-1] ~^ bm[WIDTH-1]) & (a[WIDTH-1] ^ sum[WIDTH-1]);
    case (op[1:0])
      2'b00:   y = a & bm;
      2'b01:   y = a | bm;
      2'b10:   y = sum;
      default: y = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
    endcase
    ov   = (op[1:0] == 2'b10) & ovf;
    zero = (y == '0);
    neg  = y[WIDTH-1];
  end
endmodule

module ula_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [2:0]       op0,
  input  logic [2:0]       op1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] res,
  output logic             fov,
  output logic             fz,
  output logic             fn,
  output logic             err,
  output logic             busy
);
  typedef enum logic {IDLE, EXEC} state_t;

  state_t           state, state_nx;
  logic             load, finish, win;
  logic             owner, last;
  logic [WIDTH-1:0] a_r, b_r;
  logic [2:0]       op_r;
  logic [2:0]       ula_op;
  logic [WIDTH-1:0] ula_y, res_nx;
  logic             ula_ov, ula_z, ula_n;
  logic             fov_nx, fz_nx, fn_nx, err_nx;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // On a tie the requester that did not win last time is chosen
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    finish   = 1'b0;
    win      = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          load     = 1'b1;
          state_nx = EXEC;
          win      = (req0 && req1) ? ~last : req1;
        end
      end
      EXEC: begin
        finish   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef ULA_ARB_OPCHECK_EN
  logic illegal;
  always_comb begin
    illegal = (op_r == 3'b011);
    ula_op  = illegal ? 3'b000 : op_r;
    res_nx  = illegal ? '0 : ula_y;
    fov_nx  = illegal ? 1'b0 : ula_ov;
    fz_nx   = illegal ? 1'b1 : ula_z;
    fn_nx   = illegal ? 1'b0 : ula_n;
    err_nx  = illegal;
  end
`else
  always_comb begin
    ula_op = op_r;
    res_nx = ula_y;
    fov_nx = ula_ov;
    fz_nx  = ula_z;
    fn_nx  = ula_n;
    err_nx = 1'b0;
  end
`endif

  ula #(.WIDTH(WIDTH)) u_ula (
    .a    (a_r),
    .b    (b_r),
    .op   (ula_op),
    .y    (ula_y),
    .ov   (ula_ov),
    .zero (ula_z),
    .neg  (ula_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      res   <= '0;
      fov   <= 1'b0;
      fz    <= 1'b0;
      fn    <= 1'b0;
      err   <= 1'b0;
      owner <= 1'b0;
      last  <= 1'b1;
      a_r   <= '0;
      b_r   <= '0;
      op_r  <= 3'b000;
    end else begin
      gnt0  <= load & ~win;
      gnt1  <= load & win;
      done0 <= finish & ~owner;
      done1 <= finish & owner;
      if (load) begin
        a_r   <= win ? a1 : a0;
        b_r   <= win ? b1 : b0;
        op_r  <= win ? op1 : op0;
        owner <= win;
        last  <= win;
      end
      if (finish) begin
        res <= res_nx;
        fov <= fov_nx;
        fz  <= fz_nx;
        fn  <= fn_nx;
        err <= err_nx;
      end
    end
  end

  assign busy = (state == EXEC);
endmodule

// File: tb/tb_ula_arbiter.sv
// Directed bench for ula_arbiter: single-requester vector table plus tie,
// back-to-back, reset-in-EXEC and illegal-opcode sequences.

module tb_ula_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [2:0]  op0 = '0, op1 = '0;
  logic        gnt0, gnt1, done0, done1, fov, fz, fn, err, busy;
  logic [31:0] res;

  int n_checks = 0;
  int n_fail   = 0;

  ula_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .op0(op0), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .res(res), .fov(fov), .fz(fz), .fn(fn), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] res;
    logic        fov;
    logic        fz;
    logic        fn;
  } vec_t;

  vec_t vecs[10];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic ctl(input string nm, input logic g0, input logic g1,
                     input logic d0, input logic d1, input logic bz);
    check({nm, ".gnt0"},  {31'b0, gnt0},  {31'b0, g0});
    check({nm, ".gnt1"},  {31'b0, gnt1},  {31'b0, g1});
    check({nm, ".done0"}, {31'b0, done0}, {31'b0, d0});
    check({nm, ".done1"}, {31'b0, done1}, {31'b0, d1});
    check({nm, ".busy"},  {31'b0, busy},  {31'b0, bz});
  endtask

  task automatic flags(input string nm, input logic [31:0] r, input logic v,
                       input logic z, input logic n, input logic e);
    check({nm, ".res"}, res, r);
    check({nm, ".fov"}, {31'b0, fov}, {31'b0, v});
    check({nm, ".fz"},  {31'b0, fz},  {31'b0, z});
    check({nm, ".fn"},  {31'b0, fn},  {31'b0, n});
    check({nm, ".err"}, {31'b0, err}, {31'b0, e});
  endtask

  task automatic set0(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    a0 = a; b0 = b; op0 = op; req0 = 1'b1;
  endtask

  task automatic set1(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    a1 = a; b1 = b; op1 = op; req1 = 1'b1;
  endtask

  task automatic do_single(input string nm, input vec_t v);
    if (v.sel) set1(v.a, v.b, v.op);
    else       set0(v.a, v.b, v.op);
    tick;
    ctl({nm, ".grant"}, ~v.sel, v.sel, 1'b0, 1'b0, 1'b1);
    req0 = 1'b0; req1 = 1'b0;
    tick;
    ctl({nm, ".done"}, 1'b0, 1'b0, ~v.sel, v.sel, 1'b0);
    flags(nm, v.res, v.fov, v.fz, v.fn, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h7FFFFFFF, 32'h00000001, 3'b010, 32'h80000000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 32'hFFFFFFFF, 32'h00000000, 3'b111, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'hFFFFFFFF, 32'h0000FFFF, 3'b000, 32'h0000FFFF, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h00000005, 32'h00000005, 3'b110, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 3'b100, 32'h00F000F0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h00000000, 32'hFFFFFFFE, 3'b101, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 32'h00000005, 32'hFFFFFFFD, 3'b111, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 32'h80000000, 32'h7FFFFFFF, 3'b111, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h00000000, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{1'b1, 32'h12340000, 32'h00005678, 3'b001, 32'h12345678, 1'b0, 1'b0, 1'b0};

    tick; tick;
    ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    flags("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // first tie after reset goes to requester 0, then strict alternation
    set0(32'hFFFFFFFF, 32'h0000FFFF, 3'b000);
    set1(32'h80000000, 32'h00000001, 3'b110);
    tick;
    ctl("tie1.grant", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    req0 = 1'b0;
    tick;
    ctl("tie1.done", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    flags("tie1", 32'h0000FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    set0(32'h0F000000, 32'h000000F0, 3'b001);
    tick;
    ctl("tie2.grant", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    req1 = 1'b0;
    tick;
    ctl("tie2.done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    flags("tie2", 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    set1(32'h00000001, 32'h00000002, 3'b010);
    tick;
    ctl("tie3.grant", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    req0 = 1'b0;
    tick;
    ctl("tie3.done", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    flags("tie3", 32'h0F0000F0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    ctl("tie4.grant", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    req1 = 1'b0;
    tick;
    ctl("tie4.done", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    flags("tie4", 32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      do_single($sformatf("vec%0d", i), vecs[i]);
    end

    // reset while EXEC: operation dropped, outputs cleared
    set0(32'h7FFFFFFF, 32'h00000001, 3'b010);
    tick;
    ctl("rstx.grant", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1; req0 = 1'b0;
    tick;
    ctl("rstx.cleared", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    flags("rstx", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick;
    ctl("rstx.nodone", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_single("rstx.after", '{1'b0, 32'h00000002, 32'h00000003, 3'b010,
                              32'h00000005, 1'b0, 1'b0, 1'b0});

    // back-to-back: req0 held high across two operations
    set0(32'h0000F0F0, 32'h0F0F0000, 3'b001);
    tick;
    ctl("b2b1.grant", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    a0 = 32'h0; b0 = 32'h0;
    tick;
    ctl("b2b1.done", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    flags("b2b1", 32'h0F0FF0F0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    ctl("b2b2.grant", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("b2b.hold.res", res, 32'h0F0FF0F0);
    req0 = 1'b0;
    tick;
    ctl("b2b2.done", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    flags("b2b2", 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0);

    // opcode 011
    set0(32'h00000005, 32'h00000006, 3'b011);
    tick;
    ctl("op011.grant", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    req0 = 1'b0;
    tick;
    ctl("op011.done", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef ULA_ARB_OPCHECK_EN
    flags("op011", 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
`else
    check("op011.err", {31'b0, err}, 32'h0);
`endif
    tick;
    ctl("final.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ula_arbiter.md
# ula_arbiter

Two-port arbiter and sequencer that shares one `ula` (32-bit ALU: AND/OR/ADD/SUB/AND-NOT/OR-NOT/SLT) between two requesters. It captures one request at a time into operand registers, drives the internal `ula` instance, and returns the registered result and flags to the granted requester with a one-cycle done pulse. Requests are granted round-robin. The block sits between the datapath clients (e.g. execute stage, address unit) and the ALU.

## Interface
- `WIDTH`, 32, operand/result width; must equal the `ula` width (32).
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous reset, active-high
- `req0`, `req1`  in  1  request from requester 0/1; held with operands stable until `gntN`
- `a0`, `b0`, `a1`, `b1`  in  WIDTH  operands per requester
- `op0`, `op1`  in  3  ALU opcode: 000 AND, 001 OR, 010 ADD, 110 SUB, 100 A&~B, 101 A|~B, 111 SLT; 011 unused
- `gnt0`, `gnt1`  out  1  registered one-cycle pulse: request captured
- `done0`, `done1`  out  1  registered one-cycle pulse: `res` and flags valid for that requester
- `res`  out  WIDTH  result (shared bus)
- `fov`, `fz`, `fn`  out  1  overflow/zero/negative from `ula`, captured with `res`
- `err`  out  1  illegal-opcode flag, valid with `doneN` (see Configuration)
- `busy`  out  1  high while in EXEC

## Operation
- States: IDLE, EXEC. Reset → IDLE.
- IDLE, rising edge with any `reqN`=1: select winner, load `a_r`,`b_r`,`op_r`, `owner`, set `gnt<owner>`=1 next cycle, go EXEC.
- Arbitration: single request → that requester. Both → requester ≠ `last`; then `last` ← winner. Reset sets `last`=1, so requester 0 wins the first tie.
- EXEC: `ula` inputs are `a_r`,`b_r`,`op_r`. On edge: `res`,`fov`,`fz`,`fn`,`err` ← `ula` outputs; `done<owner>`=1 next cycle; go IDLE. `req*` ignored in EXEC.
- Requester deasserts `reqN` in the cycle `gntN` is high. A `reqN` still high when IDLE is re-entered is a new request (back-to-back allowed).
- `res`/flags hold their last value between done pulses.
- Loser of a tie keeps `req` high; it is served next (no starvation: at most one op of the other requester in between).

## Timing
- Reset values: `gnt0`,`gnt1`,`done0`,`done1`,`busy`,`err`,`fov`,`fz`,`fn`=0, `res`=0, state IDLE, `last`=1.
- Request sampled at edge E0 → `gntN` high in cycle after E0 (state EXEC, `busy`=1) → `doneN` high one cycle later. Latency req-sample-to-done: 2 cycles. Peak throughput: 1 op / 2 cycles.
- `gnt` and `done` are never high for both requesters in the same cycle; `gntN` and `doneM` never overlap.
- Reset in EXEC: operation discarded, no `done`, all outputs to reset values next cycle.
- Arithmetic/flags defined entirely by `ula`; no widening or truncation in this block.

## Configuration
- `ULA_ARB_OPCHECK_EN` defined: opcode 011 is not forwarded; in EXEC `res`=0, `fov`=`fn`=0, `fz`=1, `err`=1, `done` issued normally. Legal opcodes give `err`=0.
- Not defined: `op_r` forwarded to `ula` unchanged; `err` tied 0.

## Test plan
- Req0 only: a0=7FFFFFFF, b0=00000001, op0=010 → `gnt0` next cycle, `done0` one later; `res`=80000000, `fov`=1, `fz`=0, `fn`=1.
- Simultaneous first request: req0 (op 000, FFFFFFFF & 0000FFFF), req1 (op 110, 80000000−1) → req0 served first `res`=0000FFFF; req1 held, served next: `res`=7FFFFFFF, `fov`=1; second tie then grants req0 again only after req1 (alternation over 4 ops).
- SLT via req1: a1=FFFFFFFF, b1=00000000, op 111 → `res`=00000001, `done1` only; `done0` stays 0.
- Back-to-back: req0 held high across two ops (OR 0000F0F0|0F0F0000 then 00000000|00000000) → `res`=0F0FF0F0 then 00000000 with `fz`=1, dones 2 cycles apart.
- `rst` asserted in EXEC cycle → no `done`, all outputs 0, next req0 gets `gnt0` normally.
- With `ULA_ARB_OPCHECK_EN`: op0=011 → `done0` with `err`=1, `res`=0, `fz`=1; without macro `err`=0.
